flt_add_sequencer: RTL and testbench

- Batch controller for the float-add datapath (1 sign, 5 exp, 10 mantissa bits, packed into 16 bits).
- Walks a list of operand pairs in byte-wide data memory and loads each operand from two bytes.
- Runs the adder through a start/done handshake, then writes each 16-bit sum back as two bytes.
- Sits between the top-level start/done control and the shared data_mem port plus the adder unit.

---
 rtl/flt_add_sequencer_if.sv | 42 ++++
 rtl/flt_add_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_flt_add_sequencer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/flt_add_sequencer_if.sv
// Bundle between the float-add batch sequencer and its environment:
// top-level batch control, the shared byte-wide data memory port and the
// adder start/done handshake.
interface flt_add_sequencer_if #(
  parameter int CNT_W = 6
) ();
  // batch control
  logic             start;
  logic [7:0]       src_base;
  logic [7:0]       dst_base;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] pairs_done;
  // data memory port
  logic [7:0]       mem_addr;
  logic             mem_read;
  logic             mem_write;
  logic [7:0]       mem_wdata;
  logic [7:0]       mem_rdata;
  // adder handshake
  logic             add_start;
  logic [15:0]      op_a;
  logic [15:0]      op_b;
  logic             add_done;
  logic [15:0]      add_result;

  // sequencer side
  modport master (
    input  start, src_base, dst_base, count, mem_rdata, add_done, add_result,
    output mem_addr, mem_read, mem_write, mem_wdata, add_start, op_a, op_b,
           busy, done, err, pairs_done
  );

  // environment side (memory, adder, top-level control)
  modport slave (
    output start, src_base, dst_base, count, mem_rdata, add_done, add_result,
    input  mem_addr, mem_read, mem_write, mem_wdata, add_start, op_a, op_b,
           busy, done, err, pairs_done
  );
endinterface

// File: rtl/flt_add_sequencer.sv
// Batch controller for the 16-bit float adder. For each operand pair it
// reads four bytes (A hi/lo, B hi/lo), pulses the adder, waits for the
// result (with timeout) and writes the sum back as two bytes. All outputs
// are registered and decoded from the next-state values, so strobes and
// addresses line up with the state they belong to.
module flt_add_sequencer #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 6
) (
  input  logic                clk,
  input  logic                reset,
  flt_add_sequencer_if.master bus
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_WR    = 3'd4,
    S_NEXT  = 3'd5,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       k_q, k_d;            // sub-step inside RD / WR
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pairs_q, pairs_d;
  logic [7:0]       src_q, src_d;
  logic [7:0]       dst_q, dst_d;
  logic [15:0]      a_q, a_d;
  logic [15:0]      b_q, b_d;
  logic [15:0]      res_q, res_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic [7:0]       mem_addr_q, mem_addr_d;
  logic [7:0]       mem_wdata_q, mem_wdata_d;
  logic             mem_read_q, mem_read_d;
  logic             mem_write_q, mem_write_d;
  logic             add_start_q, add_start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [7:0]       idx8_s;
  logic [7:0]       rd_addr_s;
  logic [7:0]       wr_addr_s;

  // Next-state, datapath capture and registered-output decode.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    pairs_d = pairs_q;
    src_d   = src_q;
    dst_d   = dst_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    wait_d  = wait_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.start) begin
          src_d   = bus.src_base;
          dst_d   = bus.dst_base;
          cnt_d   = bus.count;
          idx_d   = '0;
          pairs_d = '0;
          k_d     = 3'd0;
          if (bus.count == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RD;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_RD: begin
        // read data trails the strobe by one cycle: step k holds byte k-1
        case (k_q)
          3'd1:    a_d[15:8] = bus.mem_rdata;
          3'd2:    a_d[7:0]  = bus.mem_rdata;
          3'd3:    b_d[15:8] = bus.mem_rdata;
          3'd4:    b_d[7:0]  = bus.mem_rdata;
          default: a_d       = a_q;
        endcase
        if (k_q == 3'd4) begin
          k_d     = 3'd0;
          state_d = S_ISSUE;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      S_ISSUE: begin
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.add_done) begin
          res_d   = bus.add_result;
          k_d     = 3'd0;
          state_d = S_WR;
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WR: begin
        if (k_q == 3'd0) begin
          k_d = 3'd1;
        end else begin
          k_d     = 3'd0;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        pairs_d = pairs_q + CNT_W'(1);
        idx_d   = idx_q + CNT_W'(1);
        if ((idx_q + CNT_W'(1)) == cnt_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // byte addresses wrap modulo 256
    idx8_s    = 8'(idx_d);
    rd_addr_s = src_d + {idx8_s[5:0], 2'b00} + {5'b00000, k_d};
    wr_addr_s = dst_d + {idx8_s[6:0], 1'b0} + {7'b0000000, k_d[0]};

    mem_read_d  = (state_d == S_RD) && (k_d < 3'd4);
    mem_write_d = (state_d == S_WR);
    if (mem_read_d) begin
      mem_addr_d  = rd_addr_s;
      mem_wdata_d = 8'h00;
    end else if (mem_write_d) begin
      mem_addr_d  = wr_addr_s;
      mem_wdata_d = (k_d == 3'd0) ? res_d[15:8] : res_d[7:0];
    end else begin
      mem_addr_d  = 8'h00;
      mem_wdata_d = 8'h00;
    end
    add_start_d = (state_d == S_ISSUE);
    busy_d      = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERR));
    done_d      = (state_d == S_DONE);
    err_d       = (state_d == S_ERR);
  end

  // State, datapath and output registers; reset aborts from any state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      k_q         <= 3'd0;
      idx_q       <= '0;
      cnt_q       <= '0;
      pairs_q     <= '0;
      src_q       <= 8'h00;
      dst_q       <= 8'h00;
      a_q         <= 16'h0000;
      b_q         <= 16'h0000;
      res_q       <= 16'h0000;
      wait_q      <= '0;
      mem_addr_q  <= 8'h00;
      mem_wdata_q <= 8'h00;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      add_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      pairs_q     <= pairs_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      wait_q      <= wait_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      add_start_q <= add_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.add_start  = add_start_q;
  assign bus.op_a       = a_q;
  assign bus.op_b       = b_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.pairs_done = pairs_q;

endmodule

// File: tb/tb_flt_add_sequencer.sv
// Scoreboard bench for flt_add_sequencer: stimulus pushes expected memory
// reads, adder operands and memory writes into queues; a negedge monitor
// pops and compares whenever the DUT strobes.
module tb_flt_add_sequencer;

  localparam int CNT_W   = 6;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;

  flt_add_sequencer_if #(.CNT_W(CNT_W)) bus ();

  flt_add_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:255];
  int          n_vec  = 0;
  int          n_fail = 0;
  logic [7:0]  rq[$];     // expected read addresses
  logic [15:0] wq[$];     // expected {addr, data} writes
  logic [31:0] oq[$];     // expected {op_a, op_b} at add_start
  logic [15:0] resq[$];   // sums the adder model returns
  int          add_lat = 1;
  bit          add_en  = 1'b1;
  int          pend    = 0;
  logic [15:0] cur_res = 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_vec++;
    n_fail++;
    $display("FAIL %s: got %0h, expected nothing", name, act);
  endtask

  // synchronous byte memory: data valid the cycle after mem_read
  always @(posedge clk) begin
    if (bus.mem_read) bus.mem_rdata <= mem[bus.mem_addr];
  end

  // adder model with programmable latency after add_start
  always @(posedge clk) begin
    bus.add_done <= 1'b0;
    if (reset) begin
      pend = 0;
    end else begin
      if (bus.add_start) begin
        cur_res = (resq.size() > 0) ? resq.pop_front() : 16'hDEAD;
        pend = add_lat;
      end
      if (pend > 0) begin
        pend = pend - 1;
        if (pend == 0 && add_en) begin
          bus.add_done   <= 1'b1;
          bus.add_result <= cur_res;
        end
      end
    end
  end

  // monitor: strobe rules plus scoreboard pops
  always @(negedge clk) begin
    chk("strobe_excl", 32'(bus.mem_read & bus.mem_write), 32'd0);
    if (!bus.mem_read && !bus.mem_write)
      chk("idle_bus", {16'h0000, bus.mem_addr, bus.mem_wdata}, 32'd0);
    if (bus.mem_read) begin
      if (rq.size() == 0) unexpected("unexp_read", 32'(bus.mem_addr));
      else chk("rd_addr", 32'(bus.mem_addr), 32'(rq.pop_front()));
    end
    if (bus.mem_write) begin
      if (wq.size() == 0) unexpected("unexp_write", {16'h0000, bus.mem_addr, bus.mem_wdata});
      else chk("wr_addr_data", {16'h0000, bus.mem_addr, bus.mem_wdata}, 32'(wq.pop_front()));
    end
    if (bus.add_start) begin
      if (oq.size() == 0) unexpected("unexp_issue", {bus.op_a, bus.op_b});
      else chk("operands", {bus.op_a, bus.op_b}, oq.pop_front());
    end
  end

  // load pair i into memory and queue what the DUT must do with it
  task automatic add_pair(input logic [7:0] src, input logic [7:0] dst, input int i,
                          input logic [15:0] a, input logic [15:0] b, input logic [15:0] res,
                          input bit wr_hi, input bit wr_lo);
    logic [7:0] rb;
    logic [7:0] wb;
    rb = src + 8'(4 * i);
    wb = dst + 8'(2 * i);
    mem[rb]         = a[15:8];
    mem[rb + 8'd1]  = a[7:0];
    mem[rb + 8'd2]  = b[15:8];
    mem[rb + 8'd3]  = b[7:0];
    for (int k = 0; k < 4; k++) rq.push_back(rb + 8'(k));
    oq.push_back({a, b});
    resq.push_back(res);
    if (wr_hi) wq.push_back({wb, res[15:8]});
    if (wr_lo) wq.push_back({wb + 8'd1, res[7:0]});
  endtask

  // pulse start for one cycle; returns at the negedge after the accepting edge
  task automatic start_batch(input logic [7:0] src, input logic [7:0] dst,
                             input logic [CNT_W-1:0] cnt);
    @(negedge clk);
    bus.src_base = src;
    bus.dst_base = dst;
    bus.count    = cnt;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  // count edges until done/err; optionally pulse a stray start at cycle poke_at
  task automatic wait_end(input int bound, input int poke_at, output int k, output bit busy_gap);
    k = 0;
    busy_gap = 1'b0;
    while (!(bus.done || bus.err) && k < bound) begin
      if (!bus.busy) busy_gap = 1'b1;
      if (k == poke_at) begin
        bus.start    = 1'b1;
        bus.src_base = 8'hA0;
        bus.count    = 6'd1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    bus.start = 1'b0;
  endtask

  task automatic chk_queues(input string tag);
    chk({tag, "_rq_empty"}, 32'(rq.size()), 32'd0);
    chk({tag, "_wq_empty"}, 32'(wq.size()), 32'd0);
    chk({tag, "_oq_empty"}, 32'(oq.size()), 32'd0);
  endtask

  initial begin
    int k;
    bit gap;
    bus.start    = 1'b0;
    bus.src_base = 8'h00;
    bus.dst_base = 8'h00;
    bus.count    = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_bus", {16'h0000, bus.mem_addr, bus.mem_wdata}, 32'd0);
    chk("rst_ops", {bus.op_a, bus.op_b}, 32'd0);
    chk("rst_flags", {20'h0, bus.mem_read, bus.mem_write, bus.add_start,
                      bus.busy, bus.done, bus.err, bus.pairs_done}, 32'd0);
    reset = 1'b0;

    // single pair: 1.0 + 2.0 = 3.0
    add_lat = 1;
    add_pair(8'd128, 8'd132, 0, 16'h3C00, 16'h4000, 16'h4200, 1'b1, 1'b1);
    start_batch(8'd128, 8'd132, 6'd1);
    wait_end(200, -1, k, gap);
    chk("t1_latency", 32'(k), 32'd10);
    chk("t1_done", 32'(bus.done), 32'd1);
    chk("t1_pairs", 32'(bus.pairs_done), 32'd1);
    chk("t1_busy_gap", 32'(gap), 32'd0);
    chk_queues("t1");

    // batch of three, adder latency 3, stray start mid-batch
    add_lat = 3;
    add_pair(8'h10, 8'h40, 0, 16'h3C00, 16'h3C00, 16'h4000, 1'b1, 1'b1);
    add_pair(8'h10, 8'h40, 1, 16'h4000, 16'h4000, 16'h4400, 1'b1, 1'b1);
    add_pair(8'h10, 8'h40, 2, 16'h3800, 16'h3400, 16'h3A00, 1'b1, 1'b1);
    start_batch(8'h10, 8'h40, 6'd3);
    wait_end(300, 15, k, gap);
    chk("t2_latency", 32'(k), 32'd36);
    chk("t2_busy_gap", 32'(gap), 32'd0);
    chk("t2_pairs", 32'(bus.pairs_done), 32'd3);
    chk("t2_done", 32'(bus.done), 32'd1);
    chk_queues("t2");

    // address wrap: 2.0 + -1.0 = 1.0
    add_lat = 1;
    add_pair(8'hFE, 8'hFF, 0, 16'h4000, 16'hBC00, 16'h3C00, 1'b1, 1'b1);
    start_batch(8'hFE, 8'hFF, 6'd1);
    wait_end(200, -1, k, gap);
    chk("t3_latency", 32'(k), 32'd10);
    chk("t3_pairs", 32'(bus.pairs_done), 32'd1);
    chk_queues("t3");

    // timeout: adder never answers
    add_en = 1'b0;
    add_pair(8'h50, 8'h60, 0, 16'h3C00, 16'h3C00, 16'h4000, 1'b0, 1'b0);
    start_batch(8'h50, 8'h60, 6'd2);
    wait_end(300, -1, k, gap);
    chk("t4_latency", 32'(k), 32'd70);
    chk("t4_err", 32'(bus.err), 32'd1);
    chk("t4_done", 32'(bus.done), 32'd0);
    chk("t4_pairs", 32'(bus.pairs_done), 32'd0);
    chk("t4_busy", 32'(bus.busy), 32'd0);
    chk_queues("t4");
    add_en = 1'b1;

    // count = 0 straight from ERR
    start_batch(8'h70, 8'h78, 6'd0);
    wait_end(20, -1, k, gap);
    chk("t5_latency", 32'(k), 32'd0);
    chk("t5_flags", {29'h0, bus.done, bus.err, bus.busy}, 32'h4);
    repeat (3) @(negedge clk);
    chk("t5_done_held", 32'(bus.done), 32'd1);
    chk_queues("t5");

    // reset during the first write cycle: lo byte must never be written
    add_pair(8'h20, 8'h30, 0, 16'h3C00, 16'h3C00, 16'h4000, 1'b1, 1'b0);
    start_batch(8'h20, 8'h30, 6'd1);
    k = 0;
    while (!bus.mem_write && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("t6_wr_cycle", 32'(k), 32'd7);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_bus", {16'h0000, bus.mem_addr, bus.mem_wdata}, 32'd0);
    chk("t6_ops", {bus.op_a, bus.op_b}, 32'd0);
    chk("t6_flags", {20'h0, bus.mem_read, bus.mem_write, bus.add_start,
                     bus.busy, bus.done, bus.err, bus.pairs_done}, 32'd0);
    repeat (5) @(negedge clk);
    chk("t6_idle", {30'h0, bus.busy, bus.done}, 32'd0);
    chk_queues("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // hard stop if the stimulus ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
